// File: rtl/dcache_mem_stage_pkg.sv
// Shared types for the MEM-stage data cache: FSM states and store byte-mask shapes.
package dcache_mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [7:0] BYTE_MASK  = 8'h01;
   localparam logic [7:0] HALF_MASK  = 8'h03;
   localparam logic [7:0] WORD_MASK  = 8'h0F;
   localparam logic [7:0] DWORD_MASK = 8'hFF;

endpackage

// File: rtl/dcache_array.sv
// Valid bits, tag RAM and data RAM for the direct-mapped cache.
// Combinational read; synchronous byte-masked write; valid bits clear synchronously on rst.
module dcache_array #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_W      = 55
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [63:0]           rd_data,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [7:0]            wr_mask,
   input  logic [63:0]           wr_data,
   input  logic                  wr_tag_en,
   input  logic [TAG_W-1:0]      wr_tag
);
   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [63:0]      data_mem [LINES];

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (we && wr_tag_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Tag and data contents survive reset; only the valid bits are cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 8; b++) begin
            if (wr_mask[b]) begin
               data_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
         if (wr_tag_en) begin
            tag_mem[wr_index] <= wr_tag;
         end
      end
   end

endmodule

// File: rtl/dcache_mem_stage.sv
// MEM-stage direct-mapped write-through cache; load hit completes in the request cycle,
// misses and all stores take 1 + N + 1 cycles, the pipeline is stalled until data_ready.
module dcache_mem_stage
   import dcache_mem_stage_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int ADDR_W     = 64,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic [7:0]        dm_w_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   output logic [63:0]       rdata,
   output logic              data_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_be,
   input  logic              mem_ack,
   input  logic [63:0]       mem_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int TAG_W = ADDR_W - INDEX_BITS - 3;

   state_t            state;
   logic [ADDR_W-1:3] line_q;
   logic [63:0]       wdata_q;
   logic [7:0]        be_q;
   logic              hit_q;
   logic [63:0]       rdata_q;

   logic              store;
   logic              load;
   logic              hit;
   logic              load_hit;
   logic              arr_valid;
   logic [TAG_W-1:0]  arr_tag;
   logic [63:0]       arr_data;
   logic              arr_we;
   logic              unused_offset;

   assign unused_offset = ^addr[2:0];

   assign store    = |dm_w_en;
   assign load     = read && !store;
   assign hit      = arr_valid && (arr_tag == addr[ADDR_W-1:INDEX_BITS+3]);
   assign load_hit = !rst && (state == IDLE) && load && hit;

   // Refill writes the whole line and its tag; a store only merges into a line that hit.
   assign arr_we = !rst && mem_ack &&
                   ((state == REFILL) || ((state == WRITE) && hit_q));

   dcache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .rd_index  (addr[INDEX_BITS+2:3]),
      .rd_valid  (arr_valid),
      .rd_tag    (arr_tag),
      .rd_data   (arr_data),
      .we        (arr_we),
      .wr_index  (line_q[INDEX_BITS+2:3]),
      .wr_mask   ((state == REFILL) ? DWORD_MASK : be_q),
      .wr_data   ((state == REFILL) ? mem_rdata : wdata_q),
      .wr_tag_en (state == REFILL),
      .wr_tag    (line_q[ADDR_W-1:INDEX_BITS+3])
   );

   assign mem_req    = (state == REFILL) || (state == WRITE);
   assign mem_we     = (state == WRITE);
   assign mem_addr   = {line_q, 3'b000};
   assign mem_wdata  = wdata_q;
   assign mem_be     = be_q;
   assign data_ready = load_hit || (!rst && (state == DONE));
   assign rdata      = load_hit ? arr_data : rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rdata_q  <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (store) begin
                  line_q  <= addr[ADDR_W-1:3];
                  wdata_q <= wdata;
                  be_q    <= dm_w_en;
                  hit_q   <= hit;
                  state   <= WRITE;
               end else if (load) begin
                  if (hit) begin
                     if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                  end else begin
                     line_q <= addr[ADDR_W-1:3];
                     state  <= REFILL;
                  end
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
                  if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                  state   <= DONE;
               end
            end
            WRITE: begin
               if (mem_ack) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Scoreboard bench: a line-level cache/memory model predicts each response and memory request.
module tb_dcache_mem_stage;
   import dcache_mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        read;
   logic [7:0]  dm_w_en;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [63:0] rdata;
   logic        data_ready;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   always #5 clk = ~clk;

   dcache_mem_stage dut (
      .clk        (clk),
      .rst        (rst),
      .read       (read),
      .dm_w_en    (dm_w_en),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .data_ready (data_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   typedef struct {
      logic [63:0] rdata;
      int          lat;
   } resp_t;

   typedef struct {
      logic        we;
      logic [63:0] maddr;
      logic [7:0]  be;
      logic [63:0] wd;
      logic [63:0] rd;
      int          delay;
   } mreq_t;

   resp_t sb_q[$];
   mreq_t mq[$];

   int compared   = 0;
   int mismatched = 0;

   // Reference model: cache contents per line plus a sparse backing memory.
   bit          mvalid [64];
   logic [54:0] mtag   [64];
   logic [63:0] mdata  [64];
   logic [63:0] mem_model [logic [60:0]];
   logic [63:0] last_refill = 64'h0;
   int          exp_hits    = 0;
   int          exp_misses  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old_d, input logic [63:0] new_d,
                                         input logic [7:0] m);
      logic [63:0] r = old_d;
      for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = new_d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [63:0] mem_read(input logic [60:0] line);
      if (mem_model.exists(line)) return mem_model[line];
      return {line[31:0] ^ 32'hDEADBEEF, line[31:0] ^ 32'h0BADF00D};
   endfunction

   task automatic model_reset();
      foreach (mvalid[i]) mvalid[i] = 1'b0;
      last_refill = 64'h0;
      exp_hits    = 0;
      exp_misses  = 0;
      sb_q.delete();
   endtask

   // Issues one request, predicts its outcome, holds it until data_ready, then releases it.
   task automatic do_req(input bit is_store, input logic [63:0] a, input logic [7:0] be,
                         input logic [63:0] wd, input int n);
      logic [60:0] line = a[63:3];
      int          idx  = int'(a[8:3]);
      logic [54:0] tg   = a[63:9];
      bit          hit;
      bit          done;
      logic [63:0] d;
      mreq_t       m;
      resp_t       r;
      hit = mvalid[idx] && (mtag[idx] == tg);
      m.we = is_store; m.maddr = {line, 3'b000}; m.be = be; m.wd = wd; m.rd = 64'h0; m.delay = n;
      if (is_store) begin
         mq.push_back(m);
         mem_model[line] = merge(mem_read(line), wd, be);
         if (hit) mdata[idx] = merge(mdata[idx], wd, be);
         r.rdata = last_refill;
         r.lat   = n + 2;
      end else if (hit) begin
         r.rdata = mdata[idx];
         r.lat   = 0;
         exp_hits++;
      end else begin
         d = mem_read(line);
         m.rd = d;
         mq.push_back(m);
         mvalid[idx] = 1'b1;
         mtag[idx]   = tg;
         mdata[idx]  = d;
         last_refill = d;
         exp_misses++;
         r.rdata = d;
         r.lat   = n + 2;
      end
      sb_q.push_back(r);
      read    = is_store ? 1'($urandom_range(0, 1)) : 1'b1;
      dm_w_en = is_store ? be : 8'h00;
      addr    = a;
      wdata   = is_store ? wd : {$urandom, $urandom};
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (data_ready) done = 1'b1;
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL req_timeout: no data_ready for addr 0x%0h within 200 cycles", a);
      end
      @(posedge clk);
      #1;
      read    = 1'b0;
      dm_w_en = 8'h00;
      addr    = {$urandom, $urandom};
      wdata   = {$urandom, $urandom};
   endtask

   // Response monitor: latency is counted from the first cycle the request is presented.
   int    cyc = 0;
   resp_t mon_r;
   always @(negedge clk) begin
      if (rst) begin
         cyc = 0;
      end else if (read || dm_w_en != 8'h00) begin
         if (data_ready) begin
            if (sb_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_ready: data_ready with empty scoreboard at %0t", $time);
            end else begin
               mon_r = sb_q.pop_front();
               check("rdata", rdata, mon_r.rdata);
               check("latency", 64'(cyc), 64'(mon_r.lat));
            end
            cyc = 0;
         end else begin
            cyc++;
         end
      end else if (data_ready) begin
         compared++;
         mismatched++;
         $display("FAIL idle_ready: data_ready=1 with no request at %0t", $time);
      end
   end

   // Backing-memory responder: checks each request and acknowledges after the planned delay.
   initial begin
      mreq_t m;
      bit    aborted;
      bit    expected;
      mem_ack   = 1'b0;
      mem_rdata = 64'h0;
      forever begin
         @(negedge clk);
         if (!rst && mem_req) begin
            expected = (mq.size() != 0);
            if (expected) begin
               m = mq.pop_front();
               check("mem_we", mem_we, m.we);
               check("mem_addr", mem_addr, m.maddr);
               if (m.we) begin
                  check("mem_be", mem_be, m.be);
                  check("mem_wdata", mem_wdata, m.wd);
               end
            end else begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_mem_req: addr 0x%0h we %0b at %0t", mem_addr, mem_we, $time);
               m.we = 1'b1; m.rd = 64'h0; m.delay = 0;
            end
            aborted = 1'b0;
            for (int i = 0; i < m.delay && !aborted; i++) begin
               @(negedge clk);
               if (rst) aborted = 1'b1;
               else check("mem_req_held", mem_req, 1);
            end
            if (!aborted) begin
               mem_ack   = 1'b1;
               mem_rdata = m.we ? {$urandom, $urandom} : m.rd;
               @(posedge clk);
               #1;
               mem_ack   = 1'b0;
               mem_rdata = {$urandom, $urandom};
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mreq_t       m;
      logic [54:0] tg;
      logic [2:0]  off;
      logic [7:0]  be;
      logic [63:0] a;
      rst = 1'b1; read = 1'b0; dm_w_en = 8'h00; addr = 64'h0; wdata = 64'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_mem_req", mem_req, 0);
      check("reset_data_ready", data_ready, 0);
      check("reset_rdata", rdata, 0);
      check("reset_hit_cnt", hit_cnt, 0);
      check("reset_miss_cnt", miss_cnt, 0);
      @(posedge clk);
      #1;

      do_req(0, 64'h100, 8'h00, 64'h0, 3);
      check("first_miss_cnt", miss_cnt, 1);
      check("first_hit_cnt", hit_cnt, 0);
      do_req(0, 64'h100, 8'h00, 64'h0, 0);
      check("repeat_hit_cnt", hit_cnt, 1);
      do_req(1, 64'h100, WORD_MASK, 64'h11223344, 2);
      do_req(0, 64'h100, 8'h00, 64'h0, 0);
      check("merged_low_word", {32'h0, rdata[31:0]}, 64'h11223344);
      check("store_hit_cnt", hit_cnt, 2);
      do_req(1, 64'h900, DWORD_MASK, 64'hCAFE_F00D_1234_5678, 1);
      do_req(0, 64'h900, 8'h00, 64'h0, 2);
      do_req(0, 64'h2100, 8'h00, 64'h0, 4);
      do_req(0, 64'h100, 8'h00, 64'h0, 1);
      check("conflict_miss_cnt", miss_cnt, 32'(exp_misses));

      // Reset in the middle of a refill: the pending response is abandoned.
      m.we = 1'b0; m.maddr = 64'h6100; m.be = 8'h00; m.wd = 64'h0; m.rd = 64'h0; m.delay = 10;
      mq.push_back(m);
      read = 1'b1;
      addr = 64'h6100;
      repeat (3) @(negedge clk);
      check("refill_mem_req", mem_req, 1);
      @(posedge clk);
      #1;
      rst  = 1'b1;
      read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_mid_mem_req", mem_req, 0);
      check("rst_mid_data_ready", data_ready, 0);
      check("rst_mid_miss_cnt", miss_cnt, 0);
      check("rst_mid_rdata", rdata, 0);
      @(posedge clk);
      #1;
      do_req(0, 64'h100, 8'h00, 64'h0, 2);
      check("post_rst_miss_cnt", miss_cnt, 1);

      for (int k = 0; k < 300; k++) begin
         tg  = ($urandom_range(0, 3) == 3) ? {1'b1, 54'h1} : 55'($urandom_range(0, 2));
         off = 3'($urandom_range(0, 7));
         a   = {tg, 6'($urandom_range(30, 33)), off};
         case ($urandom_range(0, 3))
            0:       be = BYTE_MASK << off;
            1:       be = HALF_MASK << {off[2:1], 1'b0};
            2:       be = WORD_MASK << {off[2], 2'b00};
            default: be = DWORD_MASK;
         endcase
         do_req($urandom_range(0, 1) == 1, a, be, {$urandom, $urandom}, $urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      check("final_hit_cnt", hit_cnt, 32'(exp_hits));
      check("final_miss_cnt", miss_cnt, 32'(exp_misses));
      check("scoreboard_drained", 64'(sb_q.size()), 0);
      check("mem_queue_drained", 64'(mq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
